fifo_stream_reader: RTL

- Read-side controller that drains a synchronous FIFO and presents its contents as a valid/ready stream.
- It sits between the FIFO read port (r_en / data_out / empty) and a downstream consumer.
- It issues FIFO reads, absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer, and sustains one word per clock when the consumer is always ready.
- It also keeps a running transfer count for debug and statistics.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_stream_reader_skid.sv | 84 ++++++++
 rtl/fifo_stream_reader.sv | 62 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and occupancy encoding for the FIFO stream reader.
// Imported by the skid buffer and the reader top level.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry head/tail skid buffer with occupancy state.
// Ports: clk, rst, capture/din (word arriving), pop (head consumed),
//        valid (registered, head present), dout (head), occ (fill level).
module fifo_stream_reader_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output occ_e                  occ
);

  occ_e                  occ_q;
  occ_e                  occ_n;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] head_n;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [DATA_WIDTH-1:0] tail_n;
  logic                  valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_n;
      head_q  <= head_n;
      tail_q  <= tail_n;
      valid_q <= (occ_n != OCC_EMPTY);
    end
  end

  // A new word lands in the head if the buffer is empty after this
  // cycle's pop, otherwise in the tail; a pop from TWO shifts tail up.
  always_comb begin
    occ_n  = occ_q;
    head_n = head_q;
    tail_n = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (capture) begin
          head_n = din;
          occ_n  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (pop && !capture) begin
          occ_n = OCC_EMPTY;
        end else if (!pop && capture) begin
          tail_n = din;
          occ_n  = OCC_TWO;
        end else if (pop && capture) begin
          head_n = din;
        end
      end
      OCC_TWO: begin
        if (pop) begin
          head_n = tail_q;
          if (capture) begin
            tail_n = din;
          end else begin
            occ_n = OCC_ONE;
          end
        end
      end
      default: begin
        occ_n = OCC_EMPTY;
      end
    endcase
  end

  assign valid = valid_q;
  assign dout  = head_q;
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream.
// Ports: clk, rst, fifo_empty/fifo_r_en/fifo_data (FIFO read side),
//        m_valid/m_ready/m_data (stream), xfer_count (transfers).
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_count
);

  occ_e                 occ;
  logic                 inflight;
  logic                 pop;
  logic [2:0]           level;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign pop = m_valid & m_ready;

  // Words held or owed after this edge; the m_ready path through pop
  // is what lets a read issue every cycle while the consumer drains.
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign fifo_r_en = !rst && !fifo_empty && (level <= 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      cnt_q    <= '0;
    end else begin
      inflight <= fifo_r_en & !fifo_empty;
      if (pop) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  fifo_stream_reader_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .capture(inflight),
    .pop    (pop),
    .din    (fifo_data),
    .valid  (m_valid),
    .dout   (m_data),
    .occ    (occ)
  );

  assign xfer_count = cnt_q;

endmodule
